// File: rtl/seq_addsub_pkg.sv
// Shared types for the sequential add/subtract unit.
// Optional feature macro: SEQ_ADDSUB_OVF_EN (adds signed-overflow reporting).
package seq_addsub_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_B2A = 2'b10,
        OP_ACC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        PASS1,
        PASS2,
        DONE
    } state_e;

endpackage

// File: rtl/rca_addsub.sv
// Combinational ripple-carry adder/subtractor built from a chain of full-adder cells.
// With SEQ_ADDSUB_OVF_EN defined, also reports two's-complement overflow on ovf_o.
module rca_addsub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SEQ_ADDSUB_OVF_EN
    ,
    output logic             ovf_o
`endif
);

    logic [WIDTH-1:0] y_eff;
    logic [WIDTH:0]   carry;

    // Subtract as x + ~y + 1: invert y and seed the chain with a carry.
    assign y_eff    = y ^ {WIDTH{sub}};
    assign carry[0] = sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_full_adder
        assign sum[i]     = x[i] ^ y_eff[i] ^ carry[i];
        assign carry[i+1] = (x[i] & y_eff[i]) | (carry[i] & (x[i] ^ y_eff[i]));
    end

    assign cout = carry[WIDTH];

`ifdef SEQ_ADDSUB_OVF_EN
    assign ovf_o = carry[WIDTH] ^ carry[WIDTH-1];
`endif

endmodule

// File: rtl/seq_addsub_unit.sv
// Multi-cycle add/sub unit with valid/ready handshakes, a running accumulator and one shared adder.
// Optional feature macro: SEQ_ADDSUB_OVF_EN (adds the ovf output and overflow tracking).
module seq_addsub_unit
    import seq_addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out
`ifdef SEQ_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] t_q, t_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c1_q, c1_d;
    logic             c_out_q, c_out_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] rca_x, rca_y, rca_sum;
    logic             rca_sub, rca_cout;

`ifdef SEQ_ADDSUB_OVF_EN
    logic             ovf1_q, ovf1_d;
    logic             ovf_q, ovf_d;
    logic             rca_ovf;
`endif

    rca_addsub #(.WIDTH(WIDTH)) u_rca (
        .x    (rca_x),
        .y    (rca_y),
        .sub  (rca_sub),
        .sum  (rca_sum),
        .cout (rca_cout)
`ifdef SEQ_ADDSUB_OVF_EN
        ,
        .ovf_o(rca_ovf)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            t_q         <= '0;
            acc_q       <= '0;
            s_q         <= '0;
            c1_q        <= 1'b0;
            c_out_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            t_q         <= t_d;
            acc_q       <= acc_d;
            s_q         <= s_d;
            c1_q        <= c1_d;
            c_out_q     <= c_out_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef SEQ_ADDSUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf1_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ovf1_q <= ovf1_d;
            ovf_q  <= ovf_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        t_d     = t_q;
        acc_d   = acc_q;
        s_d     = s_q;
        c1_d    = c1_q;
        c_out_d = c_out_q;
        rca_x   = a_q;
        rca_y   = b_q;
        rca_sub = 1'b0;
`ifdef SEQ_ADDSUB_OVF_EN
        ovf1_d  = ovf1_q;
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d    = op_e'(op);
                    a_d     = a;
                    b_d     = b;
                    state_d = PASS1;
                end
            end
            PASS1: begin
                case (op_q)
                    OP_ADD: begin rca_x = a_q;   rca_y = b_q; rca_sub = 1'b0; end
                    OP_SUB: begin rca_x = a_q;   rca_y = b_q; rca_sub = 1'b1; end
                    OP_B2A: begin rca_x = b_q;   rca_y = a_q; rca_sub = 1'b1; end
                    OP_ACC: begin rca_x = acc_q; rca_y = a_q; rca_sub = 1'b0; end
                endcase
                // B2A parks b-a in t and finishes on the second pass.
                if (op_q == OP_B2A) begin
                    t_d     = rca_sum;
                    c1_d    = rca_cout;
`ifdef SEQ_ADDSUB_OVF_EN
                    ovf1_d  = rca_ovf;
`endif
                    state_d = PASS2;
                end else begin
                    s_d     = rca_sum;
                    c_out_d = rca_cout;
`ifdef SEQ_ADDSUB_OVF_EN
                    ovf_d   = rca_ovf;
`endif
                    if (op_q == OP_ACC) begin
                        acc_d = rca_sum;
                    end
                    state_d = DONE;
                end
            end
            PASS2: begin
                rca_x   = t_q;
                rca_y   = a_q;
                rca_sub = 1'b1;
                s_d     = rca_sum;
                c_out_d = c1_q & rca_cout;
`ifdef SEQ_ADDSUB_OVF_EN
                ovf_d   = ovf1_q | rca_ovf;
`endif
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign c_out     = c_out_q;
`ifdef SEQ_ADDSUB_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Scoreboard bench for seq_addsub_unit: directed cases, backpressure, mid-op reset, then random traffic.
`timescale 1ns/1ps
module tb_seq_addsub_unit;
    import seq_addsub_pkg::*;

    localparam int unsigned W    = 16;
    localparam longint      MOD  = longint'(1) << W;
    localparam longint      SMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint      SMIN = -(longint'(1) << (W - 1));

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s;
    logic         c_out;
`ifdef SEQ_ADDSUB_OVF_EN
    logic         ovf;
`endif

    seq_addsub_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .c_out    (c_out)
`ifdef SEQ_ADDSUB_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        int           lat;
        int           cyc;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [W-1:0] m_acc = '0;
    int           cyc = 0;
    bit           seen = 1'b0;
    int           rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high
    int           errors = 0;
    int           checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        if (rdy_mode == 0) out_ready = ($urandom_range(0, 3) != 0);
        else               out_ready = (rdy_mode == 2);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic longint sv(input logic [W-1:0] x);
        return x[W-1] ? longint'(x) - MOD : longint'(x);
    endfunction

    function automatic bit sovf(input longint r);
        return (r > SMAX) || (r < SMIN);
    endfunction

    // Reference behaviour from plain integer arithmetic; latency counted in cycles from the handshake cycle.
    task automatic model(input logic [1:0] o, input logic [W-1:0] ea, input logic [W-1:0] eb, output exp_t e);
        longint       ua   = longint'(ea);
        longint       ub   = longint'(eb);
        longint       uacc = longint'(m_acc);
        longint       r;
        logic [W-1:0] t;
        e.lat = 2;
        case (o)
            2'b00: begin
                r = ua + ub; e.s = W'(r); e.c = (r >= MOD);
                e.v = sovf(sv(ea) + sv(eb));
            end
            2'b01: begin
                r = ua - ub; e.s = W'(r); e.c = (ua >= ub);
                e.v = sovf(sv(ea) - sv(eb));
            end
            2'b10: begin
                r = ub - 2 * ua; e.s = W'(r); e.c = (ub >= 2 * ua);
                t = W'(ub - ua);
                e.v = sovf(sv(eb) - sv(ea)) || sovf(sv(t) - sv(ea));
                e.lat = 3;
            end
            default: begin
                r = uacc + ua; e.s = W'(r); e.c = (r >= MOD);
                e.v = sovf(sv(m_acc) + sv(ea));
                m_acc = e.s;
            end
        endcase
    endtask

    task automatic send(input logic [1:0] o, input logic [W-1:0] ta, input logic [W-1:0] tb_v);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        in_valid = 1'b1; op = o; a = ta; b = tb_v;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", longint'(in_ready), 1);
        if (in_ready) begin
            model(o, ta, tb_v, e);
            e.cyc = cyc;
            sb_q.push_back(e);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", longint'(sb_q.size()), 0);
    endtask

    // Monitor: compare every presented result against the scoreboard head; pop on transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            chk("busy_in_ready", longint'(in_ready), 0);
            if (sb_q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                mon_e = sb_q[0];
                if (!seen) begin
                    chk("latency", longint'(cyc - mon_e.cyc), longint'(mon_e.lat));
                    seen = 1'b1;
                end
                chk("s", longint'(s), longint'(mon_e.s));
                chk("c_out", longint'(c_out), longint'(mon_e.c));
`ifdef SEQ_ADDSUB_OVF_EN
                chk("ovf", longint'(ovf), longint'(mon_e.v));
`endif
                if (out_ready) begin
                    void'(sb_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        int           n;
        logic [W-1:0] ra, rb;
        logic [1:0]   ro;
        rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_s", longint'(s), 0);
        chk("rst_c_out", longint'(c_out), 0);
        chk("rst_acc", longint'(dut.acc_q), 0);
`ifdef SEQ_ADDSUB_OVF_EN
        chk("rst_ovf", longint'(ovf), 0);
`endif
        rst_n = 1'b1;

        send(OP_ADD, 16'h0001, 16'hFFFF);
        send(OP_SUB, 16'd5, 16'd7);
        send(OP_SUB, 16'h8000, 16'h0001);
        send(OP_B2A, 16'd3, 16'd10);
        send(OP_B2A, 16'd6, 16'd10);
        drain();

        // Backpressure: result must hold while out_ready is low, then release to IDLE.
        rdy_mode = 1;
        send(OP_ADD, 16'h1234, 16'hF00D);
        n = 0;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid", longint'(out_valid), 1);
        repeat (5) @(negedge clk);
        chk("bp_hold_valid", longint'(out_valid), 1);
        rdy_mode = 2;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_valid", longint'(out_valid), 0);
        chk("bp_release_ready", longint'(in_ready), 1);

        send(OP_ACC, 16'd1, 16'd0);
        send(OP_ACC, 16'd1, 16'd0);
        send(OP_ACC, 16'd1, 16'd0);
        send(OP_ACC, 16'hFFFD, 16'd0);
        drain();

        // Mid-operation reset during the second B2A pass.
        send(OP_ACC, 16'h0055, 16'd0);
        drain();
        send(OP_B2A, 16'd3, 16'd100);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", longint'(out_valid), 0);
        chk("abort_in_ready", longint'(in_ready), 1);
        chk("abort_s", longint'(s), 0);
        chk("abort_acc", longint'(dut.acc_q), 0);
        sb_q.delete();
        seen  = 1'b0;
        m_acc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        send(OP_ADD, 16'h1111, 16'h2222);
        send(OP_ACC, 16'd5, 16'd0);
        drain();

        rdy_mode = 0;
        for (int i = 0; i < 300; i++) begin
            ro = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       ra = '0;
                1:       ra = 16'hFFFF;
                2:       ra = 16'h8000;
                3:       ra = 16'h7FFF;
                default: ra = W'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0:       rb = 16'h0001;
                1:       rb = 16'h8000;
                default: rb = W'($urandom);
            endcase
            send(ro, ra, rb);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        rdy_mode = 2;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
